// File: rtl/cnn_relu_pool.sv
// 2x2 stride-1 max pool over a 3x3 two-channel frame with shift/saturate requantization.
// Define CNN_POOL_RELU_EN to clamp pixels at zero before pooling (unsigned 0..255 outputs).
module cnn_relu_pool #(
   parameter int unsigned SHIFT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] in_data1,
   input  logic [11:0] in_data2,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [8:0]  out_data1,
   output logic [8:0]  out_data2,
   output logic        out_last,
   output logic        frame_err,
   output logic [7:0]  frame_cnt
);

   localparam int unsigned PW   = 12;
   localparam int unsigned OW   = 9;
   localparam int unsigned NPIX = 9;
   localparam int unsigned CW   = 8;

   localparam logic signed [PW-1:0] OUT_MAX = 12'sd255;
`ifdef CNN_POOL_RELU_EN
   localparam logic signed [PW-1:0] OUT_MIN = 12'sd0;
`else
   localparam logic signed [PW-1:0] OUT_MIN = -12'sd256;
`endif

   typedef enum logic {LOAD, EMIT} state_t;

   state_t                r_state, w_state_nxt;
   logic [3:0]            r_pix_cnt, w_pix_nxt;
   logic [1:0]            r_win, w_win_nxt;
   logic signed [PW-1:0]  r_buf1 [NPIX];
   logic signed [PW-1:0]  r_buf2 [NPIX];
   logic [OW-1:0]         r_data1, r_data2, w_data1_nxt, w_data2_nxt;
   logic                  r_err, w_err_nxt;
   logic [CW-1:0]         r_fcnt, w_fcnt_nxt;
   logic [1:0]            w_sel_win;
   logic [3:0]            w_base;
   logic [OW-1:0]         w_q1, w_q2;

   function automatic logic signed [PW-1:0] relu(input logic signed [PW-1:0] p);
`ifdef CNN_POOL_RELU_EN
      return p[PW-1] ? '0 : p;
`else
      return p;
`endif
   endfunction

   function automatic logic signed [PW-1:0] max4(input logic signed [PW-1:0] a, b, c, d);
      logic signed [PW-1:0] m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   function automatic logic [OW-1:0] requant(input logic signed [PW-1:0] m);
      logic signed [PW-1:0] s;
      s = m >>> SHIFT;
      if (s > OUT_MAX)      return OW'(OUT_MAX);
      else if (s < OUT_MIN) return OW'(OUT_MIN);
      else                  return OW'(s);
   endfunction

   // Window whose result is loaded next: window 0 when a frame completes, else the following one.
   always_comb begin
      w_sel_win = (r_state == EMIT) ? 2'(r_win + 2'd1) : 2'd0;
      case (w_sel_win)
         2'd0:    w_base = 4'd0;
         2'd1:    w_base = 4'd1;
         2'd2:    w_base = 4'd3;
         default: w_base = 4'd4;
      endcase
      w_q1 = requant(max4(relu(r_buf1[w_base]),        relu(r_buf1[w_base + 4'd1]),
                          relu(r_buf1[w_base + 4'd3]), relu(r_buf1[w_base + 4'd4])));
      w_q2 = requant(max4(relu(r_buf2[w_base]),        relu(r_buf2[w_base + 4'd1]),
                          relu(r_buf2[w_base + 4'd3]), relu(r_buf2[w_base + 4'd4])));
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pix_nxt   = r_pix_cnt;
      w_win_nxt   = r_win;
      w_data1_nxt = r_data1;
      w_data2_nxt = r_data2;
      w_err_nxt   = 1'b0;
      w_fcnt_nxt  = r_fcnt;
      case (r_state)
         LOAD: begin
            if (in_valid) begin
               if (r_pix_cnt == 4'd8) begin
                  // Window 0 never touches pixel 8, so it is ready on this cycle.
                  w_state_nxt = EMIT;
                  w_win_nxt   = 2'd0;
                  w_pix_nxt   = 4'd0;
                  w_data1_nxt = w_q1;
                  w_data2_nxt = w_q2;
                  w_err_nxt   = ~in_last;
               end else if (in_last) begin
                  w_err_nxt = 1'b1;
                  w_pix_nxt = 4'd0;
               end else begin
                  w_pix_nxt = r_pix_cnt + 4'd1;
               end
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (r_win == 2'd3) begin
                  w_state_nxt = LOAD;
                  w_fcnt_nxt  = r_fcnt + 8'd1;
               end else begin
                  w_win_nxt   = r_win + 2'd1;
                  w_data1_nxt = w_q1;
                  w_data2_nxt = w_q2;
               end
            end
         end
         default: w_state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= LOAD;
         r_pix_cnt <= 4'd0;
         r_win     <= 2'd0;
         r_data1   <= '0;
         r_data2   <= '0;
         r_err     <= 1'b0;
         r_fcnt    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pix_cnt <= w_pix_nxt;
         r_win     <= w_win_nxt;
         r_data1   <= w_data1_nxt;
         r_data2   <= w_data2_nxt;
         r_err     <= w_err_nxt;
         r_fcnt    <= w_fcnt_nxt;
      end
   end

   // Pixel buffer is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (r_state == LOAD && in_valid && !reset) begin
         r_buf1[r_pix_cnt] <= in_data1;
         r_buf2[r_pix_cnt] <= in_data2;
      end
   end

   assign in_ready  = (r_state == LOAD);
   assign out_valid = (r_state == EMIT);
   assign out_last  = (r_state == EMIT) && (r_win == 2'd3);
   assign out_data1 = r_data1;
   assign out_data2 = r_data2;
   assign frame_err = r_err;
   assign frame_cnt = r_fcnt;

endmodule

// File: tb/tb_cnn_relu_pool.sv
// Directed + randomized bench for cnn_relu_pool against an arithmetic pooling model.
module tb_cnn_relu_pool;
   localparam int unsigned SHIFT = 2;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_last, out_ready;
   logic [11:0] in_data1, in_data2;
   logic        in_ready, out_valid, out_last, frame_err;
   logic [8:0]  out_data1, out_data2;
   logic [7:0]  frame_cnt;

   int n_total = 0;
   int n_pass  = 0;
   int exp_fcnt = 0;
   int px1 [9];
   int px2 [9];

   cnn_relu_pool #(.SHIFT(SHIFT)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data1(in_data1), .in_data2(in_data2), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data1(out_data1), .out_data2(out_data2), .out_last(out_last),
      .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
   endtask

   // Reference: max of the 2x2 neighbourhood, floor-divide by 2^SHIFT, clamp to output range.
   function automatic int ref_pool(input int ch, input int w);
      int r0, c0, m, v, d, q, lo;
      r0 = w / 2;
      c0 = w % 2;
      m  = -100000;
      for (int dr = 0; dr < 2; dr++)
         for (int dc = 0; dc < 2; dc++) begin
            v = (ch == 1) ? px1[(r0 + dr) * 3 + c0 + dc] : px2[(r0 + dr) * 3 + c0 + dc];
`ifdef CNN_POOL_RELU_EN
            if (v < 0) v = 0;
`endif
            if (v > m) m = v;
         end
      d = 1 << SHIFT;
      q = (m >= 0) ? m / d : -((-m + d - 1) / d);
`ifdef CNN_POOL_RELU_EN
      lo = 0;
`else
      lo = -256;
`endif
      if (q > 255) q = 255;
      if (q < lo)  q = lo;
      return q;
   endfunction

   function automatic logic [15:0] enc(input int v);
      logic [8:0] t;
      t = 9'(v);
      return 16'(t);
   endfunction

   task automatic fill_rand();
      for (int i = 0; i < 9; i++) begin
         px1[i] = int'($urandom_range(4095)) - 2048;
         px2[i] = int'($urandom_range(4095)) - 2048;
      end
   endtask

   // Sends n pixels; in_last on index last_at. Returns on the negedge after the final transfer.
   task automatic send_pixels(input int n, input int last_at);
      for (int i = 0; i < n; i++) begin
         int t;
         @(negedge clk);
         t = 0;
         while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) chk("in_ready_timeout", 16'(in_ready), 16'd1);
         in_valid = 1'b1;
         in_data1 = 12'(px1[i]);
         in_data2 = 12'(px2[i]);
         in_last  = (i == last_at);
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Consumes windows starting at the negedge after the last input; returns early at stop_at.
   task automatic recv(input int stall_win, input int stall_n, input int stop_at);
      for (int w = 0; w < 4; w++) begin
         if (w > 0) @(negedge clk);
         if (w == stop_at) return;
         chk($sformatf("out_valid_w%0d", w), 16'(out_valid), 16'd1);
         chk($sformatf("in_ready_w%0d", w), 16'(in_ready), 16'd0);
         chk($sformatf("data1_w%0d", w), 16'(out_data1), enc(ref_pool(1, w)));
         chk($sformatf("data2_w%0d", w), 16'(out_data2), enc(ref_pool(2, w)));
         chk($sformatf("last_w%0d", w), 16'(out_last), (w == 3) ? 16'd1 : 16'd0);
         if (w == stall_win) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               @(negedge clk);
               chk("stall_valid", 16'(out_valid), 16'd1);
               chk("stall_in_ready", 16'(in_ready), 16'd0);
               chk("stall_data1", 16'(out_data1), enc(ref_pool(1, w)));
               chk("stall_data2", 16'(out_data2), enc(ref_pool(2, w)));
            end
            out_ready = 1'b1;
         end
         @(posedge clk);
      end
      exp_fcnt = (exp_fcnt + 1) % 256;
      @(negedge clk);
      chk("post_valid", 16'(out_valid), 16'd0);
      chk("post_in_ready", 16'(in_ready), 16'd1);
      chk("frame_cnt", 16'(frame_cnt), 16'(exp_fcnt));
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      in_data1 = '0; in_data2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_in_ready", 16'(in_ready), 16'd1);
      chk("rst_frame_cnt", 16'(frame_cnt), 16'd0);
      chk("rst_data1", 16'(out_data1), 16'd0);
      chk("rst_data2", 16'(out_data2), 16'd0);
      chk("rst_last", 16'(out_last), 16'd0);
      chk("rst_err", 16'(frame_err), 16'd0);
      reset = 1'b0;

      // Ramp on channel 1, constant negative on channel 2.
      for (int i = 0; i < 9; i++) begin px1[i] = i * 10; px2[i] = -100; end
      send_pixels(9, 8);
      chk("ramp_err", 16'(frame_err), 16'd0);
      recv(-1, 0, -1);

      // Full-scale saturation.
      for (int i = 0; i < 9; i++) begin px1[i] = 2047; px2[i] = -2048; end
      send_pixels(9, 8);
      recv(-1, 0, -1);

      // Backpressure during window 1.
      fill_rand();
      send_pixels(9, 8);
      recv(1, 5, -1);

      // Early in_last aborts the frame.
      fill_rand();
      send_pixels(5, 4);
      chk("early_err", 16'(frame_err), 16'd1);
      chk("early_valid", 16'(out_valid), 16'd0);
      @(negedge clk);
      chk("early_err_pulse", 16'(frame_err), 16'd0);
      chk("early_valid2", 16'(out_valid), 16'd0);
      chk("early_in_ready", 16'(in_ready), 16'd1);
      fill_rand();
      send_pixels(9, 8);
      chk("after_early_err", 16'(frame_err), 16'd0);
      recv(-1, 0, -1);

      // Missing in_last on the 9th pixel: flagged but still processed.
      fill_rand();
      send_pixels(9, -1);
      chk("missing_last_err", 16'(frame_err), 16'd1);
      recv(-1, 0, -1);

      // Reset while emitting window 2.
      fill_rand();
      send_pixels(9, 8);
      recv(-1, 0, 2);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", 16'(out_valid), 16'd0);
      chk("midrst_frame_cnt", 16'(frame_cnt), 16'd0);
      exp_fcnt = 0;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 16'(in_ready), 16'd1);
      chk("midrst_valid2", 16'(out_valid), 16'd0);
      fill_rand();
      send_pixels(9, 8);
      recv(-1, 0, -1);

      for (int k = 0; k < 4; k++) begin
         fill_rand();
         send_pixels(9, 8);
         recv((k == 2) ? 3 : -1, 2, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/cnn_relu_pool.md
CNN_RELU_POOL -- requirements
Module: cnn_relu_pool

Interface
REQ-001 Parameter SHIFT, default 2: arithmetic right-shift applied to each pooled value during requantization; legal range 0..3.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 in_valid  input  1  upstream pixel-pair valid.
REQ-005 in_ready  output  1  block can accept a pixel pair.
REQ-006 in_data1  input  12  signed conv-output pixel, channel 1.
REQ-007 in_data2  input  12  signed conv-output pixel, channel 2.
REQ-008 in_last  input  1  marks the final (9th) pixel of a 3x3 frame.
REQ-009 out_valid  output  1  pooled output pair valid.
REQ-010 out_ready  input  1  downstream accepts the output pair.
REQ-011 out_data1  output  9  signed requantized pooled value, channel 1.
REQ-012 out_data2  output  9  signed requantized pooled value, channel 2.
REQ-013 out_last  output  1  marks the 4th (final) output of a frame.
REQ-014 frame_err  output  1  one-cycle pulse on frame-length violation.
REQ-015 frame_cnt  output  8  count of frames fully emitted; wraps 255->0.

Function
REQ-016 A transfer occurs on any cycle with valid and ready both high; data SHALL be sampled only on a transfer.
REQ-017 Pixels arrive in raster order (row 0 col 0..2, row 1, row 2); both channels travel in the same beat.
REQ-018 FSM states: LOAD, EMIT; LOAD is entered from reset.
REQ-019 LOAD: in_ready=1, out_valid=0; each transfer stores the pair at buffer index pix_cnt and increments pix_cnt (0..8).
REQ-020 On the transfer with pix_cnt=8: go to EMIT next cycle with win=0, clear pix_cnt; if in_last=0, pulse frame_err but process the frame.
REQ-021 On a transfer with in_last=1 and pix_cnt<8: pulse frame_err, discard the partial frame, clear pix_cnt, stay in LOAD.
REQ-022 EMIT: in_ready=0; out_valid=1; outputs are those of pooling window win (0..3), held stable until an out_ready transfer.
REQ-023 Window win covers rows r=win/2..r+1 and cols c=win%2..c+1; its result is the per-channel maximum of those 4 pixels (2x2 max pool, stride 1).
REQ-024 Requantization: pooled value arithmetic-shifted right by SHIFT, then saturated to the 9-bit signed output range.
REQ-025 out_last=1 only while win=3.
REQ-026 On an output transfer with win<3, increment win; with win=3, increment frame_cnt and return to LOAD next cycle.
REQ-027 Latency: out_valid rises the cycle after the 9th input transfer; a frame with out_ready held high occupies 9+4 cycles minimum.
REQ-028 Output registers SHALL NOT change while out_valid=1 and out_ready=0.

Reset
REQ-029 When reset=1 at a clock edge: state=LOAD, pix_cnt=0, win=0, out_valid=0, out_data1=0, out_data2=0, out_last=0, frame_err=0, frame_cnt=0; the pixel buffer is not cleared.
REQ-030 Reset mid-frame (LOAD or EMIT) SHALL abandon the frame with no further outputs, and in_ready=1 the cycle after reset deasserts.

Configuration
REQ-031 Macro CNN_POOL_RELU_EN: when defined, each pixel is clamped to max(pixel,0) before pooling and outputs saturate to 0..255; when undefined, signed pooling is applied and outputs saturate to -256..255.

Verification
REQ-032 SHIFT=2; ch1 = 0,10,20,30,40,50,60,70,80, ch2 all -100, out_ready=1 -> ch1 outputs 10,12,17,20; ch2 0,0,0,0 with macro, -25 x4 without; out_last on 4th output only; frame_cnt=1.
REQ-033 ch1 all 2047, ch2 all -2048 -> ch1 255 x4; ch2 0 x4 with macro, -256 x4 without.
REQ-034 Frame of 9 pixels then out_ready low 5 cycles during win=1 -> out_data held constant, in_ready=0 throughout, win advances only after out_ready rises.
REQ-035 in_last on 5th pixel -> frame_err pulse one cycle, no out_valid, next 9-pixel frame produces normal outputs.
REQ-036 reset asserted during EMIT win=2 -> out_valid=0 the next cycle, frame_cnt=0, next full frame emits all 4 windows from win=0.
